read_addr_arbiter: RTL and testbench

READ_ADDR_ARBITER -- requirements
Module: read_addr_arbiter

---
 rtl/read_addr_arbiter_pkg.sv | 29 ++
 rtl/read_addr_arbiter_rr_arbiter2.sv | 28 ++
 rtl/read_addr_arbiter.sv | 140 ++++++++++++++
 tb/tb_read_addr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_addr_arbiter_pkg.sv
// ============================================================================
// Module  : read_addr_arbiter_pkg
// Purpose : Shared constants, FSM encoding and ARPAY field layout for the
//           two-master read address arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package read_addr_arbiter_pkg;

    localparam int c_default_id_width        = 4;
    localparam int c_default_addr_width      = 32;
    localparam int c_default_num_outstanding = 2;

    // ARPAY = {ARADDR, ARLEN[3:0], ARSIZE[2:0], ARBURST[1:0]}
    localparam int c_arburst_lsb     = 0;
    localparam int c_arsize_lsb      = 2;
    localparam int c_arlen_lsb       = 5;
    localparam int c_araddr_lsb      = 9;
    localparam int c_arpay_ctrl_bits = 9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/read_addr_arbiter_rr_arbiter2.sv
// ============================================================================
// Module  : rr_arbiter2
// Purpose : Two-way round-robin pick; on a tie the master that did not win
//           last time is chosen.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant_valid,
    output logic       o_grant_idx
);

    always_comb begin
        o_grant_valid = |i_req;
        o_grant_idx   = 1'b0;
        if (i_req == 2'b11) begin
            o_grant_idx = ~i_last_grant;
        end else if (i_req[1]) begin
            o_grant_idx = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/read_addr_arbiter.sv
// ============================================================================
// Module  : read_addr_arbiter
// Purpose : Arbitrates two AXI-style read address masters onto one slave port,
//           limits outstanding bursts and routes read responses back by ID MSB.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module read_addr_arbiter
    import read_addr_arbiter_pkg::*;
#(
    parameter int ID_WIDTH              = c_default_id_width,
    parameter int ADDR_WIDTH            = c_default_addr_width,
    parameter int NUM_OUTSTANDING_TRANS = c_default_num_outstanding
) (
    input  logic                                       clk,
    input  logic                                       clr,
    input  logic [ID_WIDTH-1:0]                        M0_ARID,
    input  logic [ADDR_WIDTH+c_arpay_ctrl_bits-1:0]    M0_ARPAY,
    input  logic                                       M0_ARVALID,
    output logic                                       M0_ARREADY,
    input  logic [ID_WIDTH-1:0]                        M1_ARID,
    input  logic [ADDR_WIDTH+c_arpay_ctrl_bits-1:0]    M1_ARPAY,
    input  logic                                       M1_ARVALID,
    output logic                                       M1_ARREADY,
    output logic [ID_WIDTH:0]                          S_ARID,
    output logic [ADDR_WIDTH+c_arpay_ctrl_bits-1:0]    S_ARPAY,
    output logic                                       S_ARVALID,
    input  logic                                       S_ARREADY,
    input  logic [ID_WIDTH:0]                          S_RID,
    input  logic                                       S_RLAST,
    input  logic                                       S_RVALID,
    output logic                                       S_RREADY,
    output logic                                       M0_RVALID,
    input  logic                                       M0_RREADY,
    output logic                                       M1_RVALID,
    input  logic                                       M1_RREADY,
    output logic [$clog2(NUM_OUTSTANDING_TRANS+1)-1:0] outstanding,
    output logic                                       underflow_err
);

    localparam int c_pay_width = ADDR_WIDTH + c_arpay_ctrl_bits;
    localparam int c_cnt_width = $clog2(NUM_OUTSTANDING_TRANS + 1);
    localparam logic [c_cnt_width-1:0] c_cnt_max = c_cnt_width'(NUM_OUTSTANDING_TRANS);
    localparam logic [c_cnt_width-1:0] c_cnt_one = c_cnt_width'(1);

    arb_state_t              r_state;
    logic                    r_last_grant;
    logic [ID_WIDTH:0]       r_arid;
    logic [c_pay_width-1:0]  r_arpay;
    logic                    r_arvalid;
    logic [c_cnt_width-1:0]  r_outstanding;
    logic                    r_underflow;

    logic w_grant_valid;
    logic w_grant_idx;
    logic w_accept;
    logic w_rlast_hs;
    logic w_unused;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req         ({M1_ARVALID, M0_ARVALID}),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // Acceptance is masked during reset so nothing is handshaken that the
    // reset is about to discard.
    assign w_accept = (r_state == ST_IDLE) && !clr && w_grant_valid
                      && (r_outstanding < c_cnt_max);

    assign M0_ARREADY = w_accept && !w_grant_idx;
    assign M1_ARREADY = w_accept &&  w_grant_idx;

    assign M0_RVALID  = S_RVALID && !S_RID[ID_WIDTH];
    assign M1_RVALID  = S_RVALID &&  S_RID[ID_WIDTH];
    assign S_RREADY   = S_RID[ID_WIDTH] ? M1_RREADY : M0_RREADY;
    assign w_rlast_hs = S_RVALID && S_RREADY && S_RLAST;

    // Low RID bits travel to the masters outside this block.
    assign w_unused = ^S_RID[ID_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_arid       <= '0;
            r_arpay      <= '0;
            r_arvalid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_SEND;
                        r_arvalid    <= 1'b1;
                        r_last_grant <= w_grant_idx;
                        r_arid       <= {w_grant_idx, (w_grant_idx ? M1_ARID : M0_ARID)};
                        r_arpay      <= w_grant_idx ? M1_ARPAY : M0_ARPAY;
                    end
                end
                ST_SEND: begin
                    if (S_ARREADY) begin
                        r_state   <= ST_IDLE;
                        r_arvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    // A simultaneous accept and burst completion cancel out.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_outstanding <= '0;
            r_underflow   <= 1'b0;
        end else if (w_accept && !w_rlast_hs) begin
            r_outstanding <= r_outstanding + c_cnt_one;
        end else if (!w_accept && w_rlast_hs) begin
            if (r_outstanding == '0) begin
                r_underflow <= 1'b1;
            end else begin
                r_outstanding <= r_outstanding - c_cnt_one;
            end
        end
    end

    assign S_ARVALID     = r_arvalid;
    assign S_ARID        = r_arid;
    assign S_ARPAY       = r_arpay;
    assign outstanding   = r_outstanding;
    assign underflow_err = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_read_addr_arbiter.sv
// ============================================================================
// Module  : tb_read_addr_arbiter
// Purpose : Self-checking bench for read_addr_arbiter with a behavioural model
//           of grant order, outstanding count and sticky underflow.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_read_addr_arbiter;

    localparam int IW  = 4;
    localparam int AW  = 32;
    localparam int PW  = AW + 9;
    localparam int LIM = 2;

    logic          clk = 1'b0;
    logic          clr;
    logic [IW-1:0] M0_ARID, M1_ARID;
    logic [PW-1:0] M0_ARPAY, M1_ARPAY;
    logic          M0_ARVALID, M1_ARVALID, M0_ARREADY, M1_ARREADY;
    logic [IW:0]   S_ARID;
    logic [PW-1:0] S_ARPAY;
    logic          S_ARVALID, S_ARREADY;
    logic [IW:0]   S_RID;
    logic          S_RLAST, S_RVALID, S_RREADY;
    logic          M0_RVALID, M0_RREADY, M1_RVALID, M1_RREADY;
    logic [1:0]    outstanding;
    logic          underflow_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic m_last;
    int   m_out;
    logic m_uflow;

    read_addr_arbiter #(
        .ID_WIDTH(IW), .ADDR_WIDTH(AW), .NUM_OUTSTANDING_TRANS(LIM)
    ) dut (
        .clk(clk), .clr(clr),
        .M0_ARID(M0_ARID), .M0_ARPAY(M0_ARPAY), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
        .M1_ARID(M1_ARID), .M1_ARPAY(M1_ARPAY), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
        .S_ARID(S_ARID), .S_ARPAY(S_ARPAY), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
        .outstanding(outstanding), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) return ~last;
        return req[1];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One RLAST handshake in a cycle with no address acceptance.
    task automatic rlast(input logic [IW:0] rid);
        S_RID = rid; S_RVALID = 1'b1; S_RLAST = 1'b1;
        M0_RREADY = 1'b1; M1_RREADY = 1'b1;
        step();
        S_RVALID = 1'b0; S_RLAST = 1'b0;
        if (m_out > 0) m_out--;
        else m_uflow = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        M0_ARID = '0; M1_ARID = '0; M0_ARPAY = '0; M1_ARPAY = '0;
        M0_ARVALID = 1'b1; M1_ARVALID = 1'b0; S_ARREADY = 1'b0;
        S_RID = '0; S_RLAST = 1'b0; S_RVALID = 1'b0; M0_RREADY = 1'b0; M1_RREADY = 1'b0;
        step();
        step();
        checks++;
        if (M0_ARREADY !== 1'b0) begin
            errors++; $display("FAIL reset_arready: got %b expected 0", M0_ARREADY);
        end
        checks++;
        if ({S_ARVALID, S_ARID, S_ARPAY, outstanding, underflow_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b id=%h pay=%h out=%0d uf=%b expected all 0",
                     S_ARVALID, S_ARID, S_ARPAY, outstanding, underflow_err);
        end
        clr = 1'b0; M0_ARVALID = 1'b0;
        m_last = 1'b1; m_out = 0; m_uflow = 1'b0;
        step();
    endtask

    task automatic test_single_grant();
        logic [PW-1:0] pay;
        pay = {32'h0000_1000, 4'd3, 3'd2, 2'd1};
        M0_ARID = 4'd3; M0_ARPAY = pay; M0_ARVALID = 1'b1; S_ARREADY = 1'b1;
        #1;
        checks++;
        if ({M0_ARREADY, M1_ARREADY} !== 2'b10) begin
            errors++; $display("FAIL single_arready: got %b%b expected 10", M0_ARREADY, M1_ARREADY);
        end
        step();
        M0_ARVALID = 1'b0; m_last = 1'b0; m_out++;
        checks++;
        if (S_ARVALID !== 1'b1 || S_ARID !== 5'h03 || S_ARPAY !== pay || int'(outstanding) != m_out) begin
            errors++;
            $display("FAIL single_send: got v=%b id=%h pay=%h out=%0d expected 1 03 %h %0d",
                     S_ARVALID, S_ARID, S_ARPAY, outstanding, pay, m_out);
        end
        step();
        checks++;
        if (S_ARVALID !== 1'b0) begin
            errors++; $display("FAIL single_done: got S_ARVALID=%b expected 0", S_ARVALID);
        end
        rlast(5'h03);
        checks++;
        if (int'(outstanding) != m_out) begin
            errors++; $display("FAIL single_drain: got %0d expected %0d", outstanding, m_out);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]    req;
        logic          w;
        logic [IW:0]   exp_id;
        logic [PW-1:0] exp_pay;
        for (int i = 0; i < 12; i++) begin
            req = (i < 4) ? 2'b11 : 2'($urandom_range(1, 3));
            M0_ARID = 4'($urandom); M1_ARID = 4'($urandom);
            M0_ARPAY = {9'($urandom), $urandom}; M1_ARPAY = {9'($urandom), $urandom};
            M0_ARVALID = req[0]; M1_ARVALID = req[1]; S_ARREADY = 1'b1;
            #1;
            w = pick(req, m_last);
            exp_id  = {w, (w ? M1_ARID : M0_ARID)};
            exp_pay = w ? M1_ARPAY : M0_ARPAY;
            checks++;
            if (M0_ARREADY !== !w || M1_ARREADY !== w) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b%b expected winner M%0d", i, M0_ARREADY, M1_ARREADY, w);
            end
            step();
            m_last = w; m_out++;
            checks++;
            if (S_ARVALID !== 1'b1 || S_ARID !== exp_id || S_ARPAY !== exp_pay
                || M0_ARREADY !== 1'b0 || M1_ARREADY !== 1'b0 || int'(outstanding) != m_out) begin
                errors++;
                $display("FAIL rr_send[%0d]: got v=%b id=%h pay=%h rdy=%b%b out=%0d expected 1 %h %h 00 %0d",
                         i, S_ARVALID, S_ARID, S_ARPAY, M0_ARREADY, M1_ARREADY, outstanding,
                         exp_id, exp_pay, m_out);
            end
            rlast(exp_id);
        end
        M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
    endtask

    task automatic test_outstanding_limit();
        logic in_send, exp_rdy, w, got;
        in_send = 1'b0;
        M0_ARVALID = 1'b1; M1_ARVALID = 1'b1; S_ARREADY = 1'b1;
        for (int c = 0; c < 8; c++) begin
            M0_ARID = 4'($urandom); M1_ARID = 4'($urandom);
            #1;
            exp_rdy = !in_send && (m_out < LIM);
            w = pick(2'b11, m_last);
            got = M0_ARREADY | M1_ARREADY;
            checks++;
            if (got !== exp_rdy || (exp_rdy && M1_ARREADY !== w)) begin
                errors++;
                $display("FAIL limit_cycle[%0d]: got %b%b expected ready=%b winner M%0d",
                         c, M0_ARREADY, M1_ARREADY, exp_rdy, w);
            end
            step();
            if (exp_rdy) begin m_last = w; m_out++; end
            in_send = exp_rdy;
        end
        checks++;
        if (int'(outstanding) != LIM) begin
            errors++; $display("FAIL limit_count: got %0d expected %0d", outstanding, LIM);
        end
        rlast({1'b0, 4'h0});
        got = 1'b0;
        for (int k = 0; k < 2 && !got; k++) begin
            #1;
            got = M0_ARREADY | M1_ARREADY;
            if (!got) step();
        end
        w = pick(2'b11, m_last);
        checks++;
        if (!got || M1_ARREADY !== w) begin
            errors++;
            $display("FAIL limit_reopen: got %b%b expected winner M%0d within 1 cycle", M0_ARREADY, M1_ARREADY, w);
        end
        step();
        if (got) begin m_last = w; m_out++; end
        M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
        step();
        rlast(5'h00);
        rlast(5'h10);
        checks++;
        if (int'(outstanding) != m_out || m_out != 0) begin
            errors++; $display("FAIL limit_drain: got %0d expected %0d", outstanding, m_out);
        end
    endtask

    task automatic test_stall();
        logic [IW:0]   exp_id;
        logic [PW-1:0] exp_pay;
        M1_ARID = 4'($urandom); M1_ARPAY = {9'($urandom), $urandom};
        M0_ARVALID = 1'b0; M1_ARVALID = 1'b1; S_ARREADY = 1'b0;
        exp_id = {1'b1, M1_ARID}; exp_pay = M1_ARPAY;
        #1;
        checks++;
        if ({M0_ARREADY, M1_ARREADY} !== 2'b01) begin
            errors++; $display("FAIL stall_grant: got %b%b expected 01", M0_ARREADY, M1_ARREADY);
        end
        step();
        m_last = 1'b1; m_out++;
        M0_ARVALID = 1'b1;
        for (int k = 0; k < 5; k++) begin
            M0_ARID = 4'($urandom); M1_ARID = 4'($urandom);
            M0_ARPAY = {9'($urandom), $urandom}; M1_ARPAY = {9'($urandom), $urandom};
            #1;
            checks++;
            if (S_ARVALID !== 1'b1 || S_ARID !== exp_id || S_ARPAY !== exp_pay
                || M0_ARREADY !== 1'b0 || M1_ARREADY !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b id=%h pay=%h rdy=%b%b expected 1 %h %h 00",
                         k, S_ARVALID, S_ARID, S_ARPAY, M0_ARREADY, M1_ARREADY, exp_id, exp_pay);
            end
            step();
        end
        S_ARREADY = 1'b1; M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
        step();
        checks++;
        if (S_ARVALID !== 1'b0) begin
            errors++; $display("FAIL stall_release: got S_ARVALID=%b expected 0", S_ARVALID);
        end
        rlast(exp_id);
    endtask

    task automatic test_simultaneous_and_underflow();
        M0_ARID = 4'($urandom); M0_ARVALID = 1'b1; S_ARREADY = 1'b1;
        step();
        m_last = 1'b0; m_out++;
        M0_ARVALID = 1'b0;
        step();
        M1_ARID = 4'($urandom); M1_ARVALID = 1'b1;
        S_RID = 5'h00; S_RVALID = 1'b1; S_RLAST = 1'b1; M0_RREADY = 1'b1;
        #1;
        checks++;
        if (M1_ARREADY !== pick(2'b10, m_last)) begin
            errors++; $display("FAIL simul_grant: got M1_ARREADY=%b expected 1", M1_ARREADY);
        end
        step();
        S_RVALID = 1'b0; S_RLAST = 1'b0; M1_ARVALID = 1'b0; m_last = 1'b1;
        checks++;
        if (int'(outstanding) != m_out) begin
            errors++; $display("FAIL simul_count: got %0d expected %0d", outstanding, m_out);
        end
        step();
        rlast(5'h10);
        checks++;
        if (int'(outstanding) != m_out || underflow_err !== m_uflow) begin
            errors++; $display("FAIL drain_no_uf: got out=%0d uf=%b expected %0d %b",
                               outstanding, underflow_err, m_out, m_uflow);
        end
        rlast(5'h00);
        step(); step(); step();
        checks++;
        if (underflow_err !== m_uflow || m_uflow !== 1'b1 || outstanding !== 2'd0) begin
            errors++; $display("FAIL underflow_sticky: got uf=%b out=%0d expected 1 0", underflow_err, outstanding);
        end
    endtask

    task automatic test_r_routing();
        logic [IW:0] rid;
        logic rv, r0, r1;
        S_RID = 5'h12; S_RVALID = 1'b1; S_RLAST = 1'b0; M0_RREADY = 1'b1; M1_RREADY = 1'b0;
        #1;
        checks++;
        if ({M1_RVALID, M0_RVALID, S_RREADY} !== 3'b100) begin
            errors++; $display("FAIL route_fixed: got %b%b%b expected 100", M1_RVALID, M0_RVALID, S_RREADY);
        end
        for (int i = 0; i < 10; i++) begin
            rid = 5'($urandom); rv = 1'($urandom); r0 = 1'($urandom); r1 = 1'($urandom);
            S_RID = rid; S_RVALID = rv; M0_RREADY = r0; M1_RREADY = r1;
            #1;
            checks++;
            if (M0_RVALID !== (rv && rid < 16) || M1_RVALID !== (rv && rid >= 16)
                || S_RREADY !== ((rid >= 16) ? r1 : r0)) begin
                errors++;
                $display("FAIL route_rand[%0d]: got rv0=%b rv1=%b srr=%b for rid=%h rv=%b rr=%b%b",
                         i, M0_RVALID, M1_RVALID, S_RREADY, rid, rv, r1, r0);
            end
        end
        S_RVALID = 1'b0;
        step();
    endtask

    task automatic test_clr_mid_send();
        M0_ARID = 4'($urandom); M0_ARVALID = 1'b1; S_ARREADY = 1'b0;
        step();
        m_out++;
        checks++;
        if (S_ARVALID !== 1'b1) begin
            errors++; $display("FAIL clr_pre_send: got S_ARVALID=%b expected 1", S_ARVALID);
        end
        clr = 1'b1;
        S_RID = 5'h10; S_RVALID = 1'b1; S_RLAST = 1'b1; M0_RREADY = 1'b0; M1_RREADY = 1'b1;
        #1;
        checks++;
        if (M1_RVALID !== 1'b1 || S_RREADY !== 1'b1 || M0_ARREADY !== 1'b0) begin
            errors++; $display("FAIL clr_comb: got rv1=%b srr=%b ardy0=%b expected 1 1 0",
                               M1_RVALID, S_RREADY, M0_ARREADY);
        end
        step();
        checks++;
        if (S_ARVALID !== 1'b0 || outstanding !== 2'd0 || underflow_err !== 1'b0) begin
            errors++; $display("FAIL clr_state: got v=%b out=%0d uf=%b expected 0 0 0",
                               S_ARVALID, outstanding, underflow_err);
        end
        step();
        clr = 1'b0; S_RVALID = 1'b0; S_RLAST = 1'b0; M0_ARVALID = 1'b0;
        m_last = 1'b1; m_out = 0; m_uflow = 1'b0;
        step();
        checks++;
        if (S_ARVALID !== 1'b0 || S_ARID !== '0 || int'(outstanding) != m_out) begin
            errors++; $display("FAIL clr_no_replay: got v=%b id=%h out=%0d expected 0 00 0",
                               S_ARVALID, S_ARID, outstanding);
        end
        M0_ARVALID = 1'b1; M1_ARVALID = 1'b1;
        #1;
        checks++;
        if (M0_ARREADY !== !pick(2'b11, m_last) || M1_ARREADY !== pick(2'b11, m_last)) begin
            errors++; $display("FAIL clr_first_tie: got %b%b expected M0 wins", M0_ARREADY, M1_ARREADY);
        end
        M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_outstanding_limit();
        test_stall();
        test_simultaneous_and_underflow();
        test_r_routing();
        test_clr_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
